mux_select_sequencer: RTL and testbench

- Upstream driver for the 8-to-1 mux stage. Accepts one parallel word per valid/ready handshake and holds it on the mux input lines.
- Steps the mux selector through lanes 0..LANES-1, dwelling DWELL cycles per lane. Flags the sample cycle of each lane so the downstream consumer can capture the mux output as a serial bitstream.
- Supports one-shot or continuous re-scan, abort, and back-to-back words with no bubble.

---
 rtl/mux_select_sequencer_if.sv | 36 +++
 rtl/mux_select_sequencer.sv | 105 ++++++++++
 tb/tb_mux_select_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_select_sequencer_if.sv
// rtl/mux_select_sequencer_if.sv - word handshake and mux drive bundle for mux_select_sequencer
// Purpose: groups the upstream word handshake, the scan controls and the mux drive / sample outputs.
// Signals:
//   in_valid/in_ready/in_data : upstream word handshake, in_data bit i feeds mux lane i
//   loop_en, abort            : scan controls from the upstream side
//   lines_out, sel_out        : registered mux input word and lane selector
//   bit_valid/first/last      : sample-cycle flags for the downstream serial capture
//   busy, done_pulse          : scan status
// master = upstream driver, slave = sequencer.
interface mux_select_sequencer_if #(
    parameter int LANES = 8,
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_data;
    logic             loop_en;
    logic             abort;
    logic [LANES-1:0] lines_out;
    logic [SEL_W-1:0] sel_out;
    logic             bit_valid;
    logic             bit_first;
    logic             bit_last;
    logic             busy;
    logic             done_pulse;

    modport master (
        output in_valid, in_data, loop_en, abort,
        input  in_ready, lines_out, sel_out, bit_valid, bit_first, bit_last, busy, done_pulse
    );

    modport slave (
        input  in_valid, in_data, loop_en, abort,
        output in_ready, lines_out, sel_out, bit_valid, bit_first, bit_last, busy, done_pulse
    );
endinterface

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - steps an 8-to-1 mux selector across a held parallel word
// Purpose: accepts one LANES-bit word per handshake, holds it on the mux input lines and walks
//          the selector through lanes 0..LANES-1, DWELL cycles per lane, flagging each sample cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mux_select_sequencer_if.slave (handshake, controls, mux drive and status outputs)
module mux_select_sequencer #(
    parameter int LANES = 8,
    parameter int SEL_W = 4,
    parameter int DWELL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    mux_select_sequencer_if.slave   bus
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(LANES - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nx;
    logic [LANES-1:0] lines, lines_nx;
    logic [SEL_W-1:0] sel, sel_nx;
    logic [DW-1:0]    dwell, dwell_nx;
    logic             done, done_nx;
    logic             ready;
    logic             sample;

    assign sample = (state == SCAN) && (dwell == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lines <= '0;
            sel   <= '0;
            dwell <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            lines <= lines_nx;
            sel   <= sel_nx;
            dwell <= dwell_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        lines_nx = lines;
        sel_nx   = sel;
        dwell_nx = dwell;
        done_nx  = 1'b0;
        ready    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    lines_nx = bus.in_data;
                    sel_nx   = '0;
                    dwell_nx = '0;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    // Abort outranks end-of-scan: no reload, no loop, no done.
                    state_nx = IDLE;
                    sel_nx   = '0;
                    dwell_nx = '0;
                end else if (sample) begin
                    dwell_nx = '0;
                    if (sel != SEL_LAST) begin
                        sel_nx = sel + 1'b1;
                    end else if (bus.loop_en) begin
                        sel_nx = '0;
                    end else begin
                        // Final cycle: a waiting word loads here so the next scan has no bubble.
                        ready   = 1'b1;
                        done_nx = 1'b1;
                        sel_nx  = '0;
                        if (bus.in_valid) begin
                            lines_nx = bus.in_data;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready   = ready & ~reset;
    assign bus.lines_out  = lines;
    assign bus.sel_out    = sel;
    assign bus.bit_valid  = sample;
    assign bus.bit_first  = sample && (sel == '0);
    assign bus.bit_last   = sample && (sel == SEL_LAST);
    assign bus.busy       = (state == SCAN);
    assign bus.done_pulse = done;
endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - self-checking bench for mux_select_sequencer (DWELL=1 and DWELL=3)
module tb_mux_select_sequencer;
    localparam int LANES = 8;
    localparam int SEL_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iv = 1'b0;
    logic [7:0] data = 8'h00;
    logic       loop_en = 1'b0;
    logic       abort = 1'b0;

    always #5 clk = ~clk;

    mux_select_sequencer_if #(.LANES(LANES), .SEL_W(SEL_W)) if1 ();
    mux_select_sequencer_if #(.LANES(LANES), .SEL_W(SEL_W)) if3 ();

    assign if1.in_valid = iv;
    assign if1.in_data  = data;
    assign if1.loop_en  = loop_en;
    assign if1.abort    = abort;
    assign if3.in_valid = iv;
    assign if3.in_data  = data;
    assign if3.loop_en  = loop_en;
    assign if3.abort    = abort;

    mux_select_sequencer #(.LANES(LANES), .SEL_W(SEL_W), .DWELL(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    mux_select_sequencer #(.LANES(LANES), .SEL_W(SEL_W), .DWELL(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a scan is just a cycle index t in 0..LANES*DWELL-1 over a held word.
    int         dw[2] = '{1, 3};
    bit         m_act[2] = '{1'b0, 1'b0};
    int         m_t[2] = '{0, 0};
    logic [7:0] m_word[2] = '{8'h00, 8'h00};
    bit         m_done[2] = '{1'b0, 1'b0};

    function automatic logic m_ready(input int i);
        int n = LANES * dw[i];
        return !reset && (!m_act[i] || (m_t[i] == n - 1 && !loop_en && !abort));
    endfunction

    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            int n;
            n = LANES * dw[i];
            if (reset) begin
                m_act[i] = 1'b0; m_t[i] = 0; m_word[i] = 8'h00; m_done[i] = 1'b0;
            end else if (!m_act[i]) begin
                m_done[i] = 1'b0;
                if (iv) begin
                    m_word[i] = data; m_act[i] = 1'b1; m_t[i] = 0;
                end
            end else begin
                m_done[i] = 1'b0;
                if (abort) begin
                    m_act[i] = 1'b0; m_t[i] = 0;
                end else if (m_t[i] == n - 1) begin
                    m_t[i] = 0;
                    if (!loop_en) begin
                        m_done[i] = 1'b1;
                        if (iv) m_word[i] = data;
                        else    m_act[i] = 1'b0;
                    end
                end else begin
                    m_t[i]++;
                end
            end
        end
    endtask

    task automatic check_regs(input int i, input logic [7:0] lines, input logic [3:0] sel,
                              input logic bv, input logic bf, input logic bl,
                              input logic busy, input logic done);
        logic [3:0] e_sel;
        logic       e_bv;
        e_sel = m_act[i] ? 4'(m_t[i] / dw[i]) : 4'd0;
        e_bv  = m_act[i] && (m_t[i] % dw[i] == dw[i] - 1);
        chk8($sformatf("m%0d_lines", i), lines, m_word[i]);
        chk4($sformatf("m%0d_sel", i), sel, e_sel);
        chk1($sformatf("m%0d_bit_valid", i), bv, e_bv);
        chk1($sformatf("m%0d_bit_first", i), bf, e_bv && e_sel == 4'd0);
        chk1($sformatf("m%0d_bit_last", i), bl, e_bv && e_sel == 4'(LANES - 1));
        chk1($sformatf("m%0d_busy", i), busy, m_act[i]);
        chk1($sformatf("m%0d_done", i), done, m_done[i]);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic l, input logic a);
        reset = r; iv = v; data = d; loop_en = l; abort = a;
        #1;
        chk1("m0_in_ready", if1.in_ready, m_ready(0));
        chk1("m1_in_ready", if3.in_ready, m_ready(1));
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_regs(0, if1.lines_out, if1.sel_out, if1.bit_valid, if1.bit_first,
                   if1.bit_last, if1.busy, if1.done_pulse);
        check_regs(1, if3.lines_out, if3.sel_out, if3.bit_valid, if3.bit_first,
                   if3.bit_last, if3.busy, if3.done_pulse);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic l, input logic a);
        drive(r, v, d, l, a);
        finish_cycle();
    endtask

    task automatic quiet();
        int n = 0;
        while ((if1.busy || if3.busy) && n < 60) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk1("quiet_timeout", if1.busy | if3.busy, 1'b0);
    endtask

    // in_f = {reset, in_valid, loop_en, abort}; exp_f = {in_ready, bit_valid, bit_first, bit_last, busy, done}
    typedef struct {
        logic [3:0] in_f;
        logic [7:0] d;
        logic [5:0] exp_f;
        logic [3:0] sel;
        logic [7:0] lines;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int f1, f3, cnt, dn;

        tbl.push_back('{4'b1000, 8'h00, 6'b000000, 4'd0, 8'h00});
        tbl.push_back('{4'b1000, 8'h00, 6'b000000, 4'd0, 8'h00});
        tbl.push_back('{4'b1000, 8'h00, 6'b000000, 4'd0, 8'h00});
        tbl.push_back('{4'b0000, 8'h00, 6'b100000, 4'd0, 8'h00});
        tbl.push_back('{4'b0100, 8'hB2, 6'b111010, 4'd0, 8'hB2});
        for (int s = 1; s <= 6; s++)
            tbl.push_back('{4'b0000, 8'h00, 6'b010010, 4'(s), 8'hB2});
        tbl.push_back('{4'b0000, 8'h00, 6'b010110, 4'd7, 8'hB2});
        tbl.push_back('{4'b0000, 8'h00, 6'b100001, 4'd0, 8'hB2});
        tbl.push_back('{4'b0000, 8'h00, 6'b100000, 4'd0, 8'hB2});

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].in_f[3], tbl[i].in_f[2], tbl[i].d, tbl[i].in_f[1], tbl[i].in_f[0]);
            chk1($sformatf("tbl%0d_in_ready", i), if1.in_ready, tbl[i].exp_f[5]);
            finish_cycle();
            chk4($sformatf("tbl%0d_sel", i), if1.sel_out, tbl[i].sel);
            chk1($sformatf("tbl%0d_bit_valid", i), if1.bit_valid, tbl[i].exp_f[4]);
            chk1($sformatf("tbl%0d_bit_first", i), if1.bit_first, tbl[i].exp_f[3]);
            chk1($sformatf("tbl%0d_bit_last", i), if1.bit_last, tbl[i].exp_f[2]);
            chk1($sformatf("tbl%0d_busy", i), if1.busy, tbl[i].exp_f[1]);
            chk1($sformatf("tbl%0d_done", i), if1.done_pulse, tbl[i].exp_f[0]);
            chk8($sformatf("tbl%0d_lines", i), if1.lines_out, tbl[i].lines);
            chk1($sformatf("tbl%0d_mux_bit", i), if1.lines_out[if1.sel_out[2:0]],
                 tbl[i].lines[tbl[i].sel[2:0]]);
        end
        quiet();

        // Dwell: DWELL=3 scan is 24 cycles, done on cycle 25; DWELL=1 done on cycle 9.
        cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        f1 = 0; f3 = 0; cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (if1.done_pulse && f1 == 0) f1 = c;
            if (if3.done_pulse && f3 == 0) f3 = c;
            if (if3.bit_valid) cnt++;
            if (c == 2) chk1("dwell_bv_c2", if3.bit_valid, 1'b0);
            if (c == 3) chk1("dwell_bv_c3", if3.bit_valid, 1'b1);
            if (c == 4) chk4("dwell_sel_c4", if3.sel_out, 4'd1);
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        chki("dwell3_done_cycle", f3, 25);
        chki("dwell1_done_cycle", f1, 9);
        chki("dwell3_bv_count", cnt, 8);
        quiet();

        // Back-to-back: second word loads on the bit_last cycle of the first.
        cycle(1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        chk1("b2b_last", if1.bit_last, 1'b1);
        cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        chk8("b2b_lines", if1.lines_out, 8'hF0);
        chk4("b2b_sel", if1.sel_out, 4'd0);
        chk1("b2b_done", if1.done_pulse, 1'b1);
        chk1("b2b_busy", if1.busy, 1'b1);
        quiet();

        // Loop: three identical scans, no done while loop_en is held.
        cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        cnt = 0; dn = 0;
        for (int c = 1; c <= 24; c++) begin
            if (if1.bit_last) cnt++;
            if (if1.done_pulse) dn++;
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chki("loop_scans", cnt, 3);
        chki("loop_dones", dn, 0);
        chk8("loop_lines", if1.lines_out, 8'h3C);
        quiet();

        // Abort at sel_out=4.
        cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        cnt = 0;
        while (if1.sel_out != 4'd4 && cnt < 10) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            cnt++;
        end
        chk4("abort_reach_sel4", if1.sel_out, 4'd4);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk1("abort_busy", if1.busy, 1'b0);
        chk4("abort_sel", if1.sel_out, 4'd0);
        chk1("abort_done", if1.done_pulse, 1'b0);
        chk8("abort_lines", if1.lines_out, 8'h5A);
        chk1("abort_in_ready", if1.in_ready, 1'b1);
        quiet();

        // Abort coincident with bit_last and in_valid.
        cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        cnt = 0;
        while (!if1.bit_last && cnt < 12) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            cnt++;
        end
        chk1("abort_last_reach", if1.bit_last, 1'b1);
        drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
        chk1("abort_last_in_ready", if1.in_ready, 1'b0);
        finish_cycle();
        chk8("abort_last_lines", if1.lines_out, 8'h11);
        chk1("abort_last_busy", if1.busy, 1'b0);
        chk1("abort_last_done", if1.done_pulse, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("abort_last_done2", if1.done_pulse, 1'b0);
        quiet();

        // Reset mid-scan at sel_out=5.
        cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        cnt = 0;
        while (if1.sel_out != 4'd5 && cnt < 10) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            cnt++;
        end
        chk4("rst_reach_sel5", if1.sel_out, 4'd5);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk4("rst_sel", if1.sel_out, 4'd0);
        chk8("rst_lines", if1.lines_out, 8'h00);
        chk1("rst_busy", if1.busy, 1'b0);
        chk1("rst_done", if1.done_pulse, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("rst_done2", if1.done_pulse, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(1'(($urandom % 200) == 0), 1'($urandom % 2), 8'($urandom),
                  1'(($urandom % 4) == 0), 1'(($urandom % 20) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
